// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and state encoding for the UART frame parser.
package uart_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int DEF_MAX_LEN = 32;
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHECK, S_DRAIN} state_t;
endpackage

// File: rtl/frame_buffer.sv
// frame_buffer: MAX_LEN x 8 payload store, one write port, asynchronous read.
module frame_buffer #(
  parameter int MAX_LEN = 32,
  parameter int IW = 5
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [IW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [IW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);
  logic [7:0] r_mem [MAX_LEN];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: extracts A5/LEN/payload/XOR-checksum frames and streams the payload.
// Define PARSER_TIMEOUT_EN to abort frames after TIMEOUT_CYCLES of inter-byte silence.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int TIMEOUT_CYCLES = 208320
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       axiiv,
  input  logic [7:0] axiid,
  output logic       axiov,
  output logic [7:0] axiod,
  output logic       axiol,
  input  logic       axiir,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       busy
);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int IW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);
  state_t r_state, w_next;
  logic [CW-1:0] r_len, r_idx;
  logic [7:0] r_xor, w_rdata;
  logic r_ok, r_err, w_ok, w_err, w_last, w_xfer, w_we, w_tmo;
  assign w_last = r_idx == r_len - CW'(1);
  assign w_xfer = r_state == S_DRAIN && axiir;
  assign w_we = r_state == S_PAYLOAD && axiiv;
`ifdef PARSER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo;
  logic w_run;
  assign w_run = r_state == S_LEN || r_state == S_PAYLOAD || r_state == S_CHECK;
  assign w_tmo = w_run && !axiiv && r_tmo == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (!rst_n) r_tmo <= '0;
    else r_tmo <= (axiiv || !w_run || w_tmo) ? '0 : r_tmo + TW'(1);
`else
  assign w_tmo = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    w_ok = 1'b0;
    w_err = 1'b0;
    if (w_tmo) begin
      w_next = S_IDLE;
      w_err = 1'b1;
    end else begin
      case (r_state)
        S_IDLE:    if (axiiv && axiid == SYNC_BYTE) w_next = S_LEN;
        S_LEN:     if (axiiv) begin
                     w_err = axiid == 8'h00 || axiid > MAX_B;
                     w_next = w_err ? S_IDLE : S_PAYLOAD;
                   end
        S_PAYLOAD: if (axiiv && w_last) w_next = S_CHECK;
        S_CHECK:   if (axiiv) begin
                     w_ok = axiid == r_xor;
                     w_err = !w_ok;
                     w_next = w_ok ? S_DRAIN : S_IDLE;
                   end
        S_DRAIN:   if (w_xfer && w_last) w_next = S_IDLE;
        default:   w_next = S_IDLE;
      endcase
    end
  end
  // Index restarts on every state change: payload fill and drain both count from 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_len <= '0;
      r_idx <= '0;
      r_xor <= 8'h00;
      r_ok <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ok <= w_ok;
      r_err <= w_err;
      if (r_state == S_LEN && axiiv) begin
        r_len <= axiid[CW-1:0];
        r_xor <= axiid;
      end
      if (w_we) r_xor <= r_xor ^ axiid;
      r_idx <= (w_next != r_state) ? '0 : (w_we || w_xfer) ? r_idx + CW'(1) : r_idx;
    end
  end
  frame_buffer #(.MAX_LEN(MAX_LEN), .IW(IW)) u_buf (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(r_idx[IW-1:0]),
    .i_wdata(axiid),
    .i_raddr(r_idx[IW-1:0]),
    .o_rdata(w_rdata)
  );
  assign axiov = r_state == S_DRAIN;
  assign axiod = axiov ? w_rdata : 8'h00;
  assign axiol = axiov && w_last;
  assign frame_ok = r_ok;
  assign frame_err = r_err;
  assign busy = r_state != S_IDLE;
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: table-driven check of framing, checksum, drain and reset behaviour.
module tb_uart_frame_parser;
`ifdef PARSER_TIMEOUT_EN
  localparam int TMO = 100;
  localparam bit TEN = 1'b1;
`else
  localparam int TMO = 208320;
  localparam bit TEN = 1'b0;
`endif
  typedef struct packed {
    logic       rst_n, v;
    logic [7:0] d;
    logic       ir, e_ov;
    logic [7:0] e_od;
    logic       e_ol, e_ok, e_er, e_bz;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, axiiv = 1'b0, axiir = 1'b0;
  logic [7:0] axiid = 8'h00;
  logic axiov, axiol, frame_ok, frame_err, busy;
  logic [7:0] axiod;
  int checks = 0, failures = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  uart_frame_parser #(.MAX_LEN(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .axiiv(axiiv), .axiid(axiid),
    .axiov(axiov), .axiod(axiod), .axiol(axiol), .axiir(axiir),
    .frame_ok(frame_ok), .frame_err(frame_err), .busy(busy)
  );
  function automatic vec_t mk(input logic r, v, input logic [7:0] d, input logic ir, ov,
                              input logic [7:0] od, input logic ol, ok, er, bz);
    return '{rst_n: r, v: v, d: d, ir: ir, e_ov: ov, e_od: od, e_ol: ol, e_ok: ok, e_er: er, e_bz: bz};
  endfunction
  task automatic add(input logic r, v, input logic [7:0] d, input logic ir, ov,
                     input logic [7:0] od, input logic ol, ok, er, bz);
    tbl.push_back(mk(r, v, d, ir, ov, od, ol, ok, er, bz));
  endtask
  task automatic apply(input vec_t t, input string name, input int n);
    rst_n = t.rst_n;
    axiiv = t.v;
    axiid = t.d;
    axiir = t.ir;
    @(posedge clk);
    #1;
    checks++;
    if ({axiov, axiod, axiol, frame_ok, frame_err, busy} !== {t.e_ov, t.e_od, t.e_ol, t.e_ok, t.e_er, t.e_bz}) begin
      failures++;
      $display("FAIL %s #%0d: got ov=%b od=%h ol=%b ok=%b err=%b busy=%b, want ov=%b od=%h ol=%b ok=%b err=%b busy=%b",
               name, n, axiov, axiod, axiol, frame_ok, frame_err, busy,
               t.e_ov, t.e_od, t.e_ol, t.e_ok, t.e_er, t.e_bz);
    end
  endtask
  initial begin
    logic [7:0] data [32];
    logic [7:0] x;
    // reset
    add(0,0,8'h00,0, 0,8'h00,0,0,0,0);
    add(0,1,8'hA5,1, 0,8'h00,0,0,0,0);
    // good frame A5 03 11 22 33 03
    add(1,1,8'hA5,1, 0,8'h00,0,0,0,1);
    add(1,1,8'h03,1, 0,8'h00,0,0,0,1);
    add(1,1,8'h11,1, 0,8'h00,0,0,0,1);
    add(1,1,8'h22,1, 0,8'h00,0,0,0,1);
    add(1,1,8'h33,1, 0,8'h00,0,0,0,1);
    add(1,1,8'h03,1, 1,8'h11,0,1,0,1);
    add(1,0,8'h00,1, 1,8'h22,0,0,0,1);
    add(1,0,8'h00,1, 1,8'h33,1,0,0,1);
    add(1,0,8'h00,1, 0,8'h00,0,0,0,0);
    // bad checksum
    add(1,1,8'hA5,1, 0,8'h00,0,0,0,1);
    add(1,1,8'h03,1, 0,8'h00,0,0,0,1);
    add(1,1,8'h11,1, 0,8'h00,0,0,0,1);
    add(1,1,8'h22,1, 0,8'h00,0,0,0,1);
    add(1,1,8'h33,1, 0,8'h00,0,0,0,1);
    add(1,1,8'h04,1, 0,8'h00,0,0,1,0);
    add(1,0,8'h00,1, 0,8'h00,0,0,0,0);
    // LEN 0 and LEN 33 rejected, then a one-byte frame
    add(1,1,8'hA5,1, 0,8'h00,0,0,0,1);
    add(1,1,8'h00,1, 0,8'h00,0,0,1,0);
    add(1,1,8'hA5,1, 0,8'h00,0,0,0,1);
    add(1,1,8'h21,1, 0,8'h00,0,0,1,0);
    add(1,1,8'hA5,1, 0,8'h00,0,0,0,1);
    add(1,1,8'h01,1, 0,8'h00,0,0,0,1);
    add(1,1,8'h7E,1, 0,8'h00,0,0,0,1);
    add(1,1,8'h7F,1, 1,8'h7E,1,1,0,1);
    add(1,0,8'h00,1, 0,8'h00,0,0,0,0);
    // garbage in IDLE
    add(1,1,8'h00,1, 0,8'h00,0,0,0,0);
    add(1,1,8'hFF,1, 0,8'h00,0,0,0,0);
    add(1,1,8'h5A,1, 0,8'h00,0,0,0,0);
    // backpressure with bytes arriving during drain
    add(1,1,8'hA5,0, 0,8'h00,0,0,0,1);
    add(1,1,8'h03,0, 0,8'h00,0,0,0,1);
    add(1,1,8'h11,0, 0,8'h00,0,0,0,1);
    add(1,1,8'h22,0, 0,8'h00,0,0,0,1);
    add(1,1,8'h33,0, 0,8'h00,0,0,0,1);
    add(1,1,8'h03,0, 1,8'h11,0,1,0,1);
    add(1,1,8'h55,0, 1,8'h11,0,0,0,1);
    add(1,1,8'hA5,0, 1,8'h11,0,0,0,1);
    add(1,0,8'h00,0, 1,8'h11,0,0,0,1);
    add(1,0,8'h00,0, 1,8'h11,0,0,0,1);
    add(1,0,8'h00,1, 1,8'h22,0,0,0,1);
    add(1,0,8'h00,1, 1,8'h33,1,0,0,1);
    add(1,0,8'h00,1, 0,8'h00,0,0,0,0);
    // sync byte inside payload is data
    add(1,1,8'hA5,1, 0,8'h00,0,0,0,1);
    add(1,1,8'h02,1, 0,8'h00,0,0,0,1);
    add(1,1,8'hA5,1, 0,8'h00,0,0,0,1);
    add(1,1,8'h01,1, 0,8'h00,0,0,0,1);
    add(1,1,8'hA6,1, 1,8'hA5,0,1,0,1);
    add(1,0,8'h00,1, 1,8'h01,1,0,0,1);
    add(1,0,8'h00,1, 0,8'h00,0,0,0,0);
    foreach (tbl[i]) apply(tbl[i], "table", i);
    // maximum length frame
    x = 8'h20;
    apply(mk(1,1,8'hA5,1, 0,8'h00,0,0,0,1), "maxlen_sync", 0);
    apply(mk(1,1,8'h20,1, 0,8'h00,0,0,0,1), "maxlen_len", 0);
    for (int k = 0; k < 32; k++) begin
      data[k] = 8'(k * 7 + 3);
      x ^= data[k];
      apply(mk(1,1,data[k],1, 0,8'h00,0,0,0,1), "maxlen_payload", k);
    end
    apply(mk(1,1,x,1, 1,data[0],0,1,0,1), "maxlen_chk", 0);
    for (int j = 1; j < 32; j++)
      apply(mk(1,0,8'h00,1, 1,data[j],j == 31,0,0,1), "maxlen_drain", j);
    apply(mk(1,0,8'h00,1, 0,8'h00,0,0,0,0), "maxlen_done", 0);
    // reset mid-payload abandons the frame silently
    apply(mk(1,1,8'hA5,1, 0,8'h00,0,0,0,1), "rst_mid", 0);
    apply(mk(1,1,8'h03,1, 0,8'h00,0,0,0,1), "rst_mid", 1);
    apply(mk(1,1,8'h11,1, 0,8'h00,0,0,0,1), "rst_mid", 2);
    apply(mk(0,1,8'h22,1, 0,8'h00,0,0,0,0), "rst_mid", 3);
    apply(mk(1,0,8'h00,1, 0,8'h00,0,0,0,0), "rst_mid", 4);
    apply(mk(1,1,8'h33,1, 0,8'h00,0,0,0,0), "rst_mid", 5);
    // stalled frame: aborts after TMO cycles if enabled, otherwise waits
    apply(mk(1,1,8'hA5,1, 0,8'h00,0,0,0,1), "stall", 0);
    apply(mk(1,1,8'h03,1, 0,8'h00,0,0,0,1), "stall", 0);
    apply(mk(1,1,8'h11,1, 0,8'h00,0,0,0,1), "stall", 0);
    for (int k = 1; k <= (TEN ? 101 : 120); k++)
      apply(mk(1,0,8'h00,1, 0,8'h00,0,0,TEN && k == 100,!TEN || k < 100), "stall_wait", k);
    apply(mk(0,0,8'h00,1, 0,8'h00,0,0,0,0), "stall_reset", 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
